// File: rtl/ram32_march_bist.sv
// ram32_march_bist: March C- test engine driving the RAM32 macro port (EN0/A0/WE0/Di0, Do0).
// Optional macro BIST_FAIL_STOP_EN ends the run at the first miscompare.
module ram32_march_bist #(
  parameter int unsigned       ADDR_W  = 5,
  parameter int unsigned       DATA_W  = 32,
  parameter logic [DATA_W-1:0] PATTERN = 32'h5555_AAAA
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [ADDR_W-1:0]     fail_addr,
  output logic [7:0]            fail_count,
  output logic                  ram_en,
  output logic [ADDR_W-1:0]     ram_a,
  output logic [DATA_W/8-1:0]   ram_we,
  output logic [DATA_W-1:0]     ram_di,
  input  logic [DATA_W-1:0]     ram_do
);

  typedef enum logic [2:0] {IDLE, WR, RD, CHK, FIN} state_t;

  localparam logic [2:0]        LAST_ELEM = 3'd5;
  localparam logic [ADDR_W-1:0] ADDR_MAX  = '1;

  state_t              state_q, state_d;
  logic [2:0]          elem_q, elem_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                pass_q, pass_d;
  logic [ADDR_W-1:0]   fail_addr_q, fail_addr_d;
  logic [7:0]          fail_count_q, fail_count_d;

  logic                elem_down;
  logic                last_addr;
  logic                has_write;
  logic                mismatch;
  logic                stop;
  logic [ADDR_W-1:0]   addr_step;
  logic [DATA_W-1:0]   exp_word;
  logic [DATA_W-1:0]   wr_word;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      elem_q       <= '0;
      addr_q       <= '0;
      pass_q       <= 1'b0;
      fail_addr_q  <= '0;
      fail_count_q <= '0;
    end else begin
      state_q      <= state_d;
      elem_q       <= elem_d;
      addr_q       <= addr_d;
      pass_q       <= pass_d;
      fail_addr_q  <= fail_addr_d;
      fail_count_q <= fail_count_d;
    end
  end

  always_comb begin
    // Elements M1,M3,M5 read D0 and M0,M2,M4 write D0; elements from M3 on run downwards.
    elem_down = (elem_q >= 3'd3);
    last_addr = elem_down ? (addr_q == '0) : (addr_q == ADDR_MAX);
    has_write = (elem_q != LAST_ELEM);
    exp_word  = elem_q[0] ? PATTERN : ~PATTERN;
    wr_word   = elem_q[0] ? ~PATTERN : PATTERN;
    addr_step = elem_down ? addr_q - 1'b1 : addr_q + 1'b1;
    mismatch  = (state_q == CHK) && (ram_do != exp_word);
`ifdef BIST_FAIL_STOP_EN
    stop      = mismatch && (fail_count_q == '0);
`else
    stop      = 1'b0;
`endif

    state_d      = state_q;
    elem_d       = elem_q;
    addr_d       = addr_q;
    pass_d       = pass_q;
    fail_addr_d  = fail_addr_q;
    fail_count_d = fail_count_q;
    ram_en       = 1'b0;
    ram_a        = '0;
    ram_we       = '0;
    ram_di       = '0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d      = WR;
          elem_d       = '0;
          addr_d       = '0;
          pass_d       = 1'b1;
          fail_addr_d  = '0;
          fail_count_d = '0;
        end
      end
      WR: begin
        ram_en = 1'b1;
        ram_a  = addr_q;
        ram_we = '1;
        ram_di = wr_word;
        if (last_addr) begin
          state_d = RD;
          elem_d  = 3'd1;
          addr_d  = '0;
        end else begin
          addr_d  = addr_step;
        end
      end
      RD: begin
        ram_en  = 1'b1;
        ram_a   = addr_q;
        state_d = CHK;
      end
      CHK: begin
        if (mismatch) begin
          pass_d = 1'b0;
          if (fail_count_q == '0) fail_addr_d = addr_q;
          if (fail_count_q != 8'hFF) fail_count_d = fail_count_q + 8'd1;
        end
        if (stop) begin
          state_d = FIN;
        end else begin
          if (has_write) begin
            ram_en = 1'b1;
            ram_a  = addr_q;
            ram_we = '1;
            ram_di = wr_word;
          end
          if (last_addr) begin
            if (elem_q == LAST_ELEM) begin
              state_d = FIN;
            end else begin
              state_d = RD;
              elem_d  = elem_q + 3'd1;
              addr_d  = (elem_q >= 3'd2) ? ADDR_MAX : '0;
            end
          end else begin
            state_d = RD;
            addr_d  = addr_step;
          end
        end
      end
      FIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign busy       = (state_q == WR) || (state_q == RD) || (state_q == CHK);
  assign done       = (state_q == FIN);
  assign pass       = pass_q;
  assign fail_addr  = fail_addr_q;
  assign fail_count = fail_count_q;

endmodule
